// File: rtl/seg_msg_scanner_if.sv
// rtl/seg_msg_scanner_if.sv - control, register-file and display signals of seg_msg_scanner
//
// Purpose: bundles the ATM-control handshake, the register-file read port and the
//          display pins so the scanner and its environment connect through one port.
// Signals:
//   START, STOP        control pulses from the ATM FSM
//   MSG_BASE, MSG_LEN  message window, sampled on an accepted START
//   DATA               7-bit code returned by the register file (combinational on RA)
//   RA3..RA0           registered register-file read address
//   SEG, AN            segment code and active-low one-hot digit enables
//   BUSY, DONE         status: not idle / message pass complete (1-cycle pulse)
//   PAUSE              scroll freeze, present only with SEG_SCROLL_PAUSE_EN defined
// Modports: master = environment (control + register file), slave = scanner.

interface seg_msg_scanner_if #(
    parameter int DIGITS = 4
);
    logic              START;
    logic              STOP;
    logic [3:0]        MSG_BASE;
    logic [4:0]        MSG_LEN;
    logic [6:0]        DATA;
    logic              RA3;
    logic              RA2;
    logic              RA1;
    logic              RA0;
    logic [6:0]        SEG;
    logic [DIGITS-1:0] AN;
    logic              BUSY;
    logic              DONE;
`ifdef SEG_SCROLL_PAUSE_EN
    logic              PAUSE;

    modport master (
        output START, STOP, MSG_BASE, MSG_LEN, DATA, PAUSE,
        input  RA3, RA2, RA1, RA0, SEG, AN, BUSY, DONE
    );
    modport slave (
        input  START, STOP, MSG_BASE, MSG_LEN, DATA, PAUSE,
        output RA3, RA2, RA1, RA0, SEG, AN, BUSY, DONE
    );
`else
    modport master (
        output START, STOP, MSG_BASE, MSG_LEN, DATA,
        input  RA3, RA2, RA1, RA0, SEG, AN, BUSY, DONE
    );
    modport slave (
        input  START, STOP, MSG_BASE, MSG_LEN, DATA,
        output RA3, RA2, RA1, RA0, SEG, AN, BUSY, DONE
    );
`endif
endinterface

// File: rtl/seg_msg_scanner.sv
// rtl/seg_msg_scanner.sv - seven-segment message sequencer over a 16-entry code register file
//
// Purpose: reads a window of MSG_LEN codes starting at MSG_BASE from the register file and
//          time-multiplexes them onto a DIGITS-wide common-anode display, scrolling one
//          position every SCROLL_FRAMES frames when the message is longer than the display.
// Ports:
//   CLK  system clock, rising edge
//   CLR  asynchronous active-high reset
//   bus  seg_msg_scanner_if.slave (START/STOP/MSG_BASE/MSG_LEN/DATA in,
//        RA3..RA0/SEG/AN/BUSY/DONE out, PAUSE in when enabled)
// Optional feature: define SEG_SCROLL_PAUSE_EN to add PAUSE, which freezes the frame
//          counter and scroll offset (and suppresses DONE) while digit scanning continues.

module seg_msg_scanner #(
    parameter int DIGITS        = 4,
    parameter int PRESCALE      = 1000,
    parameter int SCROLL_FRAMES = 64
) (
    input logic             CLK,
    input logic             CLR,
    seg_msg_scanner_if.slave bus
);
    localparam int SW = $clog2(PRESCALE);
    localparam int FW = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;

    typedef enum logic [1:0] {IDLE, FETCH, SHOW} state_t;

    state_t            state_q, state_d;
    logic [3:0]        base_q, base_d;
    logic [4:0]        len_q, len_d;
    logic [4:0]        off_q, off_d;
    logic [3:0]        dig_q, dig_d;
    logic [SW-1:0]     slot_q, slot_d;
    logic [FW-1:0]     frame_q, frame_d;
    logic [3:0]        ra_q, ra_d;
    logic [6:0]        seg_q, seg_d;
    logic [DIGITS-1:0] an_q, an_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [4:0] idx_sum;
    logic [4:0] idx;
    logic       blank;
    logic       len_ok;
    logic       pause;

`ifdef SEG_SCROLL_PAUSE_EN
    assign pause = bus.PAUSE;
`else
    assign pause = 1'b0;
`endif

    // offset < len and (when scrolling) digit < len, so one subtraction wraps the index
    assign idx_sum = off_q + {1'b0, dig_q};
    assign idx     = (idx_sum >= len_q) ? (idx_sum - len_q) : idx_sum;
    // digits past the end of a short message are shown blank
    assign blank   = ({1'b0, dig_q} >= len_q);
    assign len_ok  = (bus.MSG_LEN != 5'd0) && (bus.MSG_LEN <= 5'd16);

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        len_d   = len_q;
        off_d   = off_q;
        dig_d   = dig_q;
        slot_d  = slot_q;
        frame_d = frame_q;
        ra_d    = ra_q;
        seg_d   = seg_q;
        an_d    = an_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                an_d  = '1;
                seg_d = 7'b0;
            end
            FETCH: begin
                ra_d    = 4'({1'b0, base_q} + idx);
                slot_d  = '0;
                state_d = SHOW;
            end
            SHOW: begin
                if (slot_q == '0) begin
                    seg_d = blank ? 7'b0 : bus.DATA;
                    an_d  = ~(DIGITS'(1) << dig_q);
                end
                if (slot_q == SW'(PRESCALE - 2)) begin
                    // blank the anodes during the next FETCH to avoid ghosting
                    an_d    = '1;
                    state_d = FETCH;
                    if (dig_q == 4'(DIGITS - 1)) begin
                        dig_d = 4'd0;
                        if (!pause) begin
                            if (frame_q == FW'(SCROLL_FRAMES - 1)) begin
                                frame_d = '0;
                                if (len_q > 5'(DIGITS)) begin
                                    if (5'(off_q + 5'd1) == len_q) begin
                                        off_d  = 5'd0;
                                        done_d = 1'b1;
                                    end else begin
                                        off_d = off_q + 5'd1;
                                    end
                                end else begin
                                    done_d = 1'b1;
                                end
                            end else begin
                                frame_d = frame_q + FW'(1);
                            end
                        end
                    end else begin
                        dig_d = dig_q + 4'd1;
                    end
                end else begin
                    slot_d = slot_q + SW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // accepted START (also a restart while busy) drops the current pass without DONE
        if (bus.START && len_ok && !bus.STOP) begin
            base_d  = bus.MSG_BASE;
            len_d   = bus.MSG_LEN;
            off_d   = 5'd0;
            dig_d   = 4'd0;
            slot_d  = '0;
            frame_d = '0;
            an_d    = '1;
            done_d  = 1'b0;
            state_d = FETCH;
        end

        if (bus.STOP && (state_q != IDLE)) begin
            state_d = IDLE;
            an_d    = '1;
            seg_d   = 7'b0;
            done_d  = 1'b0;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state_q <= IDLE;
            base_q  <= 4'd0;
            len_q   <= 5'd0;
            off_q   <= 5'd0;
            dig_q   <= 4'd0;
            slot_q  <= '0;
            frame_q <= '0;
            ra_q    <= 4'd0;
            seg_q   <= 7'b0;
            an_q    <= '1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            len_q   <= len_d;
            off_q   <= off_d;
            dig_q   <= dig_d;
            slot_q  <= slot_d;
            frame_q <= frame_d;
            ra_q    <= ra_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.RA3  = ra_q[3];
    assign bus.RA2  = ra_q[2];
    assign bus.RA1  = ra_q[1];
    assign bus.RA0  = ra_q[0];
    assign bus.SEG  = seg_q;
    assign bus.AN   = an_q;
    assign bus.BUSY = busy_q;
    assign bus.DONE = done_q;

endmodule

// File: tb/tb_seg_msg_scanner.sv
// tb/tb_seg_msg_scanner.sv - directed scoreboard bench for seg_msg_scanner

module tb_seg_msg_scanner;
    localparam int DIGITS   = 4;
    localparam int PRESCALE = 4;
    localparam int SF       = 2;

    typedef struct {
        logic [3:0] ra;
        logic [6:0] seg;
        logic [3:0] an;
        bit         blank;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seg_msg_scanner_if #(.DIGITS(DIGITS)) bus ();

    logic [6:0] mem [16];
    assign bus.DATA = mem[{bus.RA3, bus.RA2, bus.RA1, bus.RA0}];

    seg_msg_scanner #(
        .DIGITS       (DIGITS),
        .PRESCALE     (PRESCALE),
        .SCROLL_FRAMES(SF)
    ) dut (
        .CLK(clk),
        .CLR(rst),
        .bus(bus)
    );

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];

    int m_base, m_len, m_off, m_d, m_frame;
    bit m_pend_done, m_pause;

    function automatic logic [3:0] ra_now();
        return {bus.RA3, bus.RA2, bus.RA1, bus.RA0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_msg(input int b, input int l);
        bus.MSG_BASE = 4'(b);
        bus.MSG_LEN  = 5'(l);
        bus.START    = 1'b1;
        @(negedge clk);
        bus.START    = 1'b0;
        m_base = b; m_len = l; m_off = 0; m_d = 0; m_frame = 0; m_pend_done = 0;
    endtask

    // entered at the negedge inside a FETCH cycle; leaves at the next slot's FETCH negedge
    task automatic run_slots(input int n);
        for (int s = 0; s < n; s++) begin
            exp_t e;
            int   idx;
            idx = m_off + m_d;
            if (idx >= m_len) idx -= m_len;
            e.blank = (m_d >= m_len);
            e.ra    = 4'((m_base + idx) % 16);
            e.seg   = e.blank ? 7'b0 : mem[e.ra];
            e.an    = 4'(~(4'b0001 << m_d));
            sb.push_back(e);
            chk("fetch_an", bus.AN, 32'hF);
            chk("done_at_fetch", bus.DONE, m_pend_done);
            chk("busy", bus.BUSY, 1);
            @(negedge clk);
            e = sb.pop_front();
            if (!e.blank) chk("ra", ra_now(), e.ra);
            @(negedge clk);
            chk("seg", bus.SEG, e.seg);
            chk("an", bus.AN, e.an);
            chk("done_in_show", bus.DONE, 0);
            repeat (PRESCALE - 2) @(negedge clk);
            m_pend_done = 0;
            m_d++;
            if (m_d == DIGITS) begin
                m_d = 0;
                if (!m_pause) begin
                    if (m_frame == SF - 1) begin
                        m_frame = 0;
                        if (m_len > DIGITS) begin
                            m_off++;
                            if (m_off == m_len) begin
                                m_off = 0;
                                m_pend_done = 1;
                            end
                        end else begin
                            m_pend_done = 1;
                        end
                    end else begin
                        m_frame++;
                    end
                end
            end
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, bus.BUSY, 0);
        chk({tag, "_an"}, bus.AN, 32'hF);
        chk({tag, "_seg"}, bus.SEG, 0);
        chk({tag, "_done"}, bus.DONE, 0);
    endtask

    initial begin
        for (int a = 0; a < 16; a++) mem[a] = 7'(a + 14);
        m_pause      = 0;
        bus.START    = 1'b0;
        bus.STOP     = 1'b0;
        bus.MSG_BASE = 4'd0;
        bus.MSG_LEN  = 5'd0;
`ifdef SEG_SCROLL_PAUSE_EN
        bus.PAUSE    = 1'b0;
`endif
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_idle("reset");
        chk("reset_ra", ra_now(), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk_idle("idle_no_start");

        // static message: codes 0x10..0x13 at addresses 2..5
        start_msg(2, 4);
        run_slots(17);

        // asynchronous reset in the middle of a SHOW slot
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk_idle("async_clr");
        chk("async_clr_ra", ra_now(), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk_idle("after_clr");

        // scroll with address wrap
        start_msg(14, 6);
        run_slots(4 * 13);

        // short message: digits 2 and 3 blank
        start_msg(8, 2);
        run_slots(9);

        // START and STOP together while busy: STOP wins
        bus.MSG_LEN = 5'd4;
        bus.START   = 1'b1;
        bus.STOP    = 1'b1;
        @(negedge clk);
        bus.START   = 1'b0;
        bus.STOP    = 1'b0;
        chk_idle("start_stop");
        repeat (3) @(negedge clk);
        chk_idle("start_stop_hold");

        // restart in the cycle that would have produced DONE
        start_msg(2, 4);
        run_slots(7);
        repeat (PRESCALE - 1) @(negedge clk);
        start_msg(14, 6);
        run_slots(5);

        // plain STOP, then illegal lengths in IDLE
        bus.STOP = 1'b1;
        @(negedge clk);
        bus.STOP = 1'b0;
        chk_idle("stop");
        bus.MSG_LEN = 5'd0;
        bus.START   = 1'b1;
        @(negedge clk);
        bus.START   = 1'b0;
        @(negedge clk);
        chk_idle("len0");
        bus.MSG_LEN = 5'd17;
        bus.START   = 1'b1;
        @(negedge clk);
        bus.START   = 1'b0;
        @(negedge clk);
        chk_idle("len17");

`ifdef SEG_SCROLL_PAUSE_EN
        start_msg(14, 6);
        run_slots(6);
        bus.PAUSE = 1'b1;
        m_pause   = 1;
        run_slots(20);
        bus.PAUSE = 1'b0;
        m_pause   = 0;
        run_slots(4 * 14);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/seg_msg_scanner.md
Name: seg_msg_scanner

Overview:
- Sequencer for the 16-entry seven-segment code register file. It drives the file's read address (RA3..RA0), captures the returned 7-bit code, and time-multiplexes it onto a DIGITS-wide common-anode display.
- Messages are windows of MSG_LEN entries starting at MSG_BASE. If a message is longer than the display, it scrolls one position every SCROLL_FRAMES full scan frames.
- Sits between the ATM control FSM (START/STOP/DONE) and the display pins.

Parameters:
- DIGITS, 4, number of display digits (1..8).
- PRESCALE, 1000, clock cycles per digit slot (>=2).
- SCROLL_FRAMES, 64, full scan frames per scroll step (>=1).

Ports:
- CLK  in  1  system clock, rising edge.
- CLR  in  1  reset, asynchronous, active-high.
- START  in  1  one-cycle pulse; latch MSG_BASE/MSG_LEN and begin scanning.
- STOP  in  1  one-cycle pulse; return to idle.
- MSG_BASE  in  4  first register-file address of the message.
- MSG_LEN  in  5  message length in entries, 1..16.
- DATA  in  7  code from the register file, combinational on RA.
- RA3, RA2, RA1, RA0  out  1 each  register-file read address, registered.
- SEG  out  7  segment code to the pins.
- AN  out  DIGITS  digit enables, active-low, one-hot-low.
- BUSY  out  1  high whenever not in IDLE.
- DONE  out  1  one-cycle pulse when a message pass completes.

Behaviour:
- Reset (async, CLR=1):
  - state=IDLE; RA=0; SEG=7'b0; AN=all ones; BUSY=0; DONE=0.
  - All counters (slot, digit, frame, offset) = 0.
- States: IDLE, FETCH, SHOW.
- IDLE:
  - AN=all ones, SEG=0.
  - START with MSG_LEN in 1..16: latch base and len, zero all counters, go to FETCH.
  - START with MSG_LEN=0 or >16: ignored.
- FETCH (1 cycle):
  - RA <= (base + idx) mod 16, 4-bit wrap.
  - idx = offset + d; if idx >= len then idx -= len. A single subtraction suffices because offset < len and, when scrolling, d < len.
  - AN=all ones during FETCH (anti-ghosting). Go to SHOW.
- SHOW (PRESCALE-1 cycles):
  - On the first SHOW cycle, SEG <= DATA, or 7'b0 if d >= len (blank digit).
  - SEG holds its value for the rest of the slot.
  - AN[d]=0 from the first SHOW cycle (registered with SEG); all other AN bits stay 1.
  - On the last SHOW cycle: d <= d+1 and go to FETCH. If d was DIGITS-1, d <= 0 and the frame ends.
- Frame end:
  - frame <= frame+1.
  - When frame reaches SCROLL_FRAMES-1 at frame end: frame <= 0 and this counts as a scroll step.
- Scroll step:
  - len > DIGITS: offset <= offset+1; if the result equals len, offset <= 0 and DONE pulses for 1 cycle.
  - len <= DIGITS: offset stays 0; DONE pulses on every scroll step.
- Scanning continues until STOP.
- Slot period is exactly PRESCALE cycles (1 FETCH + PRESCALE-1 SHOW). Frame period = DIGITS*PRESCALE.
- STOP, in any non-IDLE state, returns to IDLE on the next edge with IDLE outputs.
  - STOP and START in the same cycle: STOP wins.
- START while BUSY: restart. Re-latch base/len, zero counters, go to FETCH next cycle. No DONE is generated for the aborted message.
- MSG_BASE/MSG_LEN are only sampled on an accepted START.
- Address wrap: base=14, len=4 reads 14, 15, 0, 1.

Optional Feature:
- Macro SEG_SCROLL_PAUSE_EN.
- Defined:
  - Adds input port PAUSE (1 bit).
  - While PAUSE=1, the frame counter and offset hold, and no DONE is generated. Digit scanning continues normally.
  - Releasing PAUSE resumes from the held frame count.
- Undefined: no PAUSE port; scrolling is never frozen.

Test Plan:
1. Reset check. Assert CLR mid-SHOW with DIGITS=4, PRESCALE=4 -> same cycle: AN=4'b1111, SEG=0, RA=0, BUSY=0. After release, stays IDLE until START.
2. Static message. START with base=2, len=4, SCROLL_FRAMES=2; file holds codes 0x10..0x13 at addresses 2..5:
   - RA sequence is 2, 3, 4, 5 repeating, one address every 4 cycles.
   - SEG follows 0x10..0x13 with AN low on digits 0..3 respectively.
   - DONE pulses every 32 cycles.
3. Scroll with wrap. base=14, len=6, DIGITS=4, SCROLL_FRAMES=1:
   - Frame 0 reads 14, 15, 0, 1; frame 1 reads 15, 0, 1, 2.
   - After 6 frames, DONE pulses once and offset returns to 0.
4. Short message. len=2, DIGITS=4 -> digits 2 and 3 show SEG=0 while their AN bit is low; digits 0 and 1 show file data.
5. Control collisions:
   - START and STOP in the same cycle while BUSY -> IDLE next cycle.
   - START while BUSY with a new base -> next FETCH uses the new base, counters restart, no spurious DONE.
   - START with MSG_LEN=0 in IDLE -> BUSY stays 0.
6. Pause (SEG_SCROLL_PAUSE_EN defined). Hold PAUSE=1 for 5 frames mid-message -> RA pattern repeats identically each frame and no DONE occurs. After release, scrolling resumes from the same offset.
